// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : readout_pkg
// Purpose  : Shared constants, the readout FSM state type and the packet
//            length helper used by the measurement readout block.
// Contents : HEADER_BYTE  - first byte of every pixel packet
//            BYTE_IDX_W   - width of the in-packet byte index (packets of up
//                           to 256 bytes, i.e. COUNTER_BITS up to 672)
//            state_t      - IDLE / SEND / DONE
//            packet_len() - bytes per pixel packet
// Revision : 1.0 - initial release
// ============================================================================
package readout_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam int unsigned BYTE_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Header + index byte, three big-endian words, optional trailing checksum.
  function automatic int unsigned packet_len(input int unsigned bytes_per_word,
                                             input bit          checksum_en);
    return 2 + 3 * bytes_per_word + (checksum_en ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/readout_checksum.sv
`default_nettype none
// ============================================================================
// Module   : readout_checksum
// Purpose  : Running XOR over the bytes of one packet.
// Ports    : clk    - system clock
//            rst    - synchronous active-high reset
//            clr_i  - restart the sum (combined with acc_i: sum := byte_i)
//            acc_i  - fold byte_i into the sum
//            byte_i - byte being accepted
//            sum_o  - XOR of all bytes folded in since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module readout_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       acc_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (acc_i) begin
      sum_d = (clr_i ? 8'h00 : sum_q) ^ byte_i;
    end else if (clr_i) begin
      sum_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/measurement_readout.sv
`default_nettype none
// ============================================================================
// Module   : measurement_readout
// Purpose  : Scans all pixels of the frequency counter array, snapshots each
//            pixel's PERIOD / TIME_HIGH / TIME_LOW words and serialises them
//            as byte packets on a valid/ready byte interface.
//            Packet: A5, pixel[7:0], PERIOD, TIME_HIGH, TIME_LOW (MSB first)
//            and, with READOUT_CHECKSUM_EN defined, a trailing XOR byte.
// Ports    : CLK, RST        - clock, synchronous active-high reset
//            START           - one-cycle frame scan request (ignored if busy)
//            PERIOD_IN       - packed periods, pixel i at [i*CB +: CB]
//            TIME_HIGH_IN    - packed high times, same packing
//            TIME_LOW_IN     - packed low times, same packing
//            DATA_OUT        - current byte
//            DATA_VALID      - DATA_OUT holds a valid byte
//            DATA_READY      - consumer accepts when DATA_VALID=1
//            DATA_LAST       - final byte of a pixel packet
//            BUSY            - frame scan in progress
//            FRAME_DONE      - one-cycle pulse after the last frame byte
// Macro    : READOUT_CHECKSUM_EN - append XOR checksum byte to each packet
// Revision : 1.0 - initial release
// ============================================================================
module measurement_readout
  import readout_pkg::*;
#(
  parameter int unsigned PIXELS       = 128,
  parameter int unsigned COUNTER_BITS = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [PIXELS*COUNTER_BITS-1:0] PERIOD_IN,
  input  logic [PIXELS*COUNTER_BITS-1:0] TIME_HIGH_IN,
  input  logic [PIXELS*COUNTER_BITS-1:0] TIME_LOW_IN,
  output logic [7:0]                     DATA_OUT,
  output logic                           DATA_VALID,
  input  logic                           DATA_READY,
  output logic                           DATA_LAST,
  output logic                           BUSY,
  output logic                           FRAME_DONE
);

  localparam int unsigned BYTES_PER_WORD = COUNTER_BITS / 8;
`ifdef READOUT_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif
  localparam int unsigned PKT_LEN    = packet_len(BYTES_PER_WORD, CHECKSUM_EN);
  localparam int unsigned WORD_BYTES = 3 * BYTES_PER_WORD;
  localparam int unsigned SNAP_BITS  = 3 * COUNTER_BITS;
  localparam int unsigned PIX_W      = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic [PIX_W-1:0]      LAST_PIX       = PIX_W'(PIXELS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX       = BYTE_IDX_W'(PKT_LEN - 1);
  localparam logic [BYTE_IDX_W-1:0] INDEX_IDX      = BYTE_IDX_W'(1);
  localparam logic [BYTE_IDX_W-1:0] FIRST_WORD_IDX = BYTE_IDX_W'(2);
  // First byte index past the measurement words (the checksum slot, if any).
  localparam logic [BYTE_IDX_W-1:0] END_WORD_IDX   = BYTE_IDX_W'(2 + WORD_BYTES);

  // --------------------------------------------------------------------------
  // Per-pixel view of the input buses: {PERIOD, TIME_HIGH, TIME_LOW}, so the
  // snapshot's most significant byte is the first word byte on the wire.
  // --------------------------------------------------------------------------
  logic [SNAP_BITS-1:0] w_pix_words [PIXELS];

  for (genvar gi = 0; gi < PIXELS; gi++) begin : g_unpack
    assign w_pix_words[gi] = {PERIOD_IN   [gi*COUNTER_BITS +: COUNTER_BITS],
                              TIME_HIGH_IN[gi*COUNTER_BITS +: COUNTER_BITS],
                              TIME_LOW_IN [gi*COUNTER_BITS +: COUNTER_BITS]};
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                state_q,  state_d;
  logic [PIX_W-1:0]      pix_q,    pix_d;
  logic [BYTE_IDX_W-1:0] byte_q,   byte_d;
  logic [SNAP_BITS-1:0]  snap_q,   snap_d;
  logic [7:0]            data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  last_q,   last_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  logic                  w_accept;
  logic                  w_advance;
  logic [SNAP_BITS-1:0]  w_shifted;
  logic [7:0]            w_cks_byte;

  // valid_q is only ever set in SEND, so this is the SEND-state handshake.
  assign w_accept = valid_q & DATA_READY;

  // --------------------------------------------------------------------------
  // Optional checksum. The byte presented in the checksum slot is computed at
  // the edge that accepts the last word byte, so it is the running sum of the
  // earlier bytes XORed with the byte being accepted at that very edge.
  // --------------------------------------------------------------------------
`ifdef READOUT_CHECKSUM_EN
  logic [7:0] w_sum;
  logic       w_cks_clr;
  logic       w_cks_acc;

  assign w_cks_clr = w_accept & (byte_q == '0);
  assign w_cks_acc = w_accept & (byte_q != LAST_IDX);

  readout_checksum u_checksum (
    .clk    (CLK),
    .rst    (RST),
    .clr_i  (w_cks_clr),
    .acc_i  (w_cks_acc),
    .byte_i (data_q),
    .sum_o  (w_sum)
  );

  assign w_cks_byte = w_sum ^ data_q;
`else
  assign w_cks_byte = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. Outputs are recomputed only when the byte position
  // moves; otherwise they hold, which gives the stall behaviour for free.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    byte_d    = byte_q;
    snap_d    = snap_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_advance = 1'b0;
    w_shifted = '0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = SEND;
          pix_d     = '0;
          byte_d    = '0;
          snap_d    = w_pix_words[0];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          w_advance = 1'b1;
        end
      end
      SEND: begin
        if (w_accept) begin
          if (byte_q == LAST_IDX) begin
            if (pix_q == LAST_PIX) begin
              state_d = DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Next pixel's header goes out with no idle cycle in between.
              pix_d     = pix_q + PIX_W'(1);
              byte_d    = '0;
              snap_d    = w_pix_words[pix_d];
              w_advance = 1'b1;
            end
          end else begin
            byte_d    = byte_q + BYTE_IDX_W'(1);
            w_advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Byte mux from the (next) snapshot registers.
    if (w_advance) begin
      last_d = (byte_d == LAST_IDX);
      if (byte_d == '0) begin
        data_d = HEADER_BYTE;
      end else if (byte_d == INDEX_IDX) begin
        data_d = 8'(pix_d);
      end else if (byte_d < END_WORD_IDX) begin
        w_shifted = snap_d << {byte_d - FIRST_WORD_IDX, 3'b000};
        data_d    = w_shifted[SNAP_BITS-1 -: 8];
      end else begin
        data_d = w_cks_byte;
      end
    end else if (state_d != SEND) begin
      data_d = 8'h00;
      last_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Readout FSM registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pix_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign DATA_LAST  = last_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_measurement_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_measurement_readout
// Purpose  : Self-checking bench for measurement_readout (PIXELS=4, 32-bit
//            counters). A packet-level reference model queues expected bytes
//            when a snapshot is due; a monitor pops and compares each byte the
//            consumer accepts. Honours READOUT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_measurement_readout;

  localparam int P   = 4;
  localparam int CB  = 32;
  localparam int BPW = CB / 8;
`ifdef READOUT_CHECKSUM_EN
  localparam int L = 3 + 3 * BPW;
`else
  localparam int L = 2 + 3 * BPW;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            START;
  logic            READY;
  logic [P*CB-1:0] per_bus;
  logic [P*CB-1:0] hi_bus;
  logic [P*CB-1:0] lo_bus;
  logic [7:0]      data_out;
  logic            data_valid;
  logic            data_last;
  logic            busy;
  logic            frame_done;

  always #5 CLK = ~CLK;

  measurement_readout #(
    .PIXELS       (P),
    .COUNTER_BITS (CB)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .PERIOD_IN    (per_bus),
    .TIME_HIGH_IN (hi_bus),
    .TIME_LOW_IN  (lo_bus),
    .DATA_OUT     (data_out),
    .DATA_VALID   (data_valid),
    .DATA_READY   (READY),
    .DATA_LAST    (data_last),
    .BUSY         (busy),
    .FRAME_DONE   (frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a frame is a list of packets; each packet's bytes are
  // built from the bus values present at the edge where that pixel is taken.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  bit   m_active  = 1'b0;
  bit   m_in_done = 1'b0;
  int   m_pix     = 0;
  int   m_cnt     = 0;

  function automatic void push_packet(input int p);
    logic [7:0]  pk[$];
    logic [31:0] w[3];
    logic [7:0]  x;
    int          n;
    w[0] = per_bus[p*CB +: CB];
    w[1] = hi_bus [p*CB +: CB];
    w[2] = lo_bus [p*CB +: CB];
    pk.push_back(8'hA5);
    pk.push_back(8'(p));
    for (int k = 0; k < 3; k++)
      for (int j = BPW - 1; j >= 0; j--)
        pk.push_back(w[k][j*8 +: 8]);
`ifdef READOUT_CHECKSUM_EN
    x = 8'h00;
    foreach (pk[i]) x = x ^ pk[i];
    pk.push_back(x);
`else
    x = 8'h00;
`endif
    n = pk.size();
    for (int i = 0; i < n; i++) exp_q.push_back('{b: pk[i], last: (i == n - 1)});
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_active  = 1'b0;
      m_in_done = 1'b0;
      exp_q.delete();
    end else if (m_in_done) begin
      m_in_done = 1'b0;
    end else if (!m_active) begin
      if (START) begin
        m_active = 1'b1;
        m_pix    = 0;
        m_cnt    = 0;
        push_packet(0);
      end
    end else if (READY) begin
      m_cnt++;
      if (m_cnt == L) begin
        m_cnt = 0;
        if (m_pix == P - 1) begin
          m_active  = 1'b0;
          m_in_done = 1'b1;
        end else begin
          m_pix++;
          push_packet(m_pix);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge, scores accepted bytes.
  // --------------------------------------------------------------------------
  logic       mon_en    = 1'b0;
  int         acc_cnt   = 0;
  int         frames    = 0;
  logic [7:0] acc_log[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  exp_t       mon_e;

  always @(negedge CLK) begin
    if (mon_en) begin
      check("valid", 32'(data_valid), 32'(m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(m_in_done));
      if (prev_hold && data_valid) begin
        check("stall_data", 32'(data_out), 32'(prev_data));
        check("stall_last", 32'(data_last), 32'(prev_last));
      end
      if (frame_done) frames++;
      if (data_valid && READY && !RST) begin
        acc_cnt++;
        acc_log.push_back(data_out);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %02h with nothing expected", data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", 32'(data_out), 32'(mon_e.b));
          check("last", 32'(data_last), 32'(mon_e.last));
        end
      end
      prev_hold = data_valid && !READY && !RST;
      prev_data = data_out;
      prev_last = data_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic randomize_buses();
    for (int p = 0; p < P; p++) begin
      per_bus[p*CB +: CB] = $urandom();
      hi_bus [p*CB +: CB] = $urandom();
      lo_bus [p*CB +: CB] = $urandom();
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_frame(input string name, output int n);
    n = 0;
    while (!frame_done && n < 1000) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end
    check(name, 32'(frame_done), 32'd1);
  endtask

  logic [7:0] gold[$];
  logic [7:0] gx;
  int         n;
  int         f0;
  int         pulses;
  int         pulse_at[5];

  initial begin
    RST     = 1'b1;
    START   = 1'b0;
    READY   = 1'b0;
    per_bus = '0;
    hi_bus  = '0;
    lo_bus  = '0;

    // ---- reset and idle ----
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    mon_en = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check("idle_valid", 32'(data_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
      check("idle_data", 32'(data_out), 32'd0);
    end

    // ---- full frame, READY held high ----
    randomize_buses();
    per_bus[2*CB +: CB] = 32'h0000_1234;
    hi_bus [2*CB +: CB] = 32'h0000_0900;
    lo_bus [2*CB +: CB] = 32'h0000_0934;
    READY = 1'b1;
    acc_log.delete();
    pulse_start();
    wait_frame("frame1_done", n);
    check("frame1_cycles", 32'(n), 32'(4 * L));
    check("frame1_busy", 32'(busy), 32'd0);
    check("frame1_bytes", 32'(acc_log.size()), 32'(4 * L));
    gold = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00,
             8'h09, 8'h00, 8'h00, 8'h00, 8'h09, 8'h34};
`ifdef READOUT_CHECKSUM_EN
    gx = 8'h00;
    foreach (gold[i]) gx = gx ^ gold[i];
    gold.push_back(gx);
`endif
    if (acc_log.size() == 4 * L) begin
      for (int i = 0; i < L; i++) check("pixel2_byte", 32'(acc_log[2*L + i]), 32'(gold[i]));
    end
    @(negedge CLK);
    check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---- random READY, inputs changing every cycle, spurious STARTs ----
    repeat (3) @(posedge CLK);
    for (int k = 0; k < 5; k++) pulse_at[k] = 3 + k * 8 + int'($urandom_range(0, 5));
    acc_log.delete();
    f0     = frames;
    pulses = 0;
    n      = 0;
    @(posedge CLK);
    #1 START = 1'b1;
    randomize_buses();
    while (frames == f0 && n < 3000) begin
      @(posedge CLK);
      #1;
      n++;
      START = 1'b0;
      if (pulses < 5 && n == pulse_at[pulses]) begin
        START = 1'b1;
        pulses++;
      end
      READY = ($urandom_range(0, 99) >= 30);
      randomize_buses();
    end
    START = 1'b0;
    READY = 1'b1;
    check("rand_frame_done", 32'(frames), 32'(f0 + 1));
    repeat (20) @(posedge CLK);
    #1;
    check("rand_single_frame", 32'(frames), 32'(f0 + 1));
    check("rand_bytes", 32'(acc_log.size()), 32'(4 * L));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---- reset mid-frame after 20 accepted bytes ----
    acc_cnt = 0;
    f0      = frames;
    pulse_start();
    n = 0;
    while (acc_cnt < 20 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    check("rst_reach_20", 32'(acc_cnt), 32'd20);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    repeat (3) @(negedge CLK);
    check("rst_no_done", 32'(frames), 32'(f0));

    // ---- restart after reset ----
    acc_log.delete();
    pulse_start();
    wait_frame("restart_done", n);
    check("restart_bytes", 32'(acc_log.size()), 32'(4 * L));
    if (acc_log.size() >= 2) begin
      check("restart_hdr", 32'(acc_log[0]), 32'hA5);
      check("restart_idx", 32'(acc_log[1]), 32'h00);
    end
    repeat (3) @(negedge CLK);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
